acl_spi_scheduler: RTL and testbench
====================================

// Module: acl_spi_scheduler
// PURPOSE
//  Transaction sequencer for the ADXL362 accelerometer. It drives a byte-level SPI engine
//  through a start/done handshake: power-up wait, DEVID check, filter and power config,
//  then periodic 6-byte burst reads of X/Y/Z.
//  It publishes aligned X/Y/Z samples to the shot-detection logic.
//  It is the only owner of the byte engine; no other requester shares it.
// PARAMETERS
//  PWRUP_TICKS   24000  iclk cycles to wait after reset, and between DEVID retries (6 ms @ 4 MHz)
//  PERIOD_TICKS  40000  sample period in iclk cycles, start-to-start (10 ms)
//  FILTER_CFG    8'h13  value written to FILTER_CTL (0x2C)
//  ID_RETRIES    3      DEVID reads attempted before the block faults
// PORTS
//  iclk          in   1   system clock, 4 MHz
//  rst           in   1   synchronous, active-high reset
//  xfer_start    out  1   1-cycle pulse: byte engine sends xfer_tx
//  xfer_tx       out  8   byte to send; valid in the xfer_start cycle
//  xfer_last     out  1   qualifies xfer_start: engine raises CS after this byte
//  xfer_busy     in   1   byte engine is shifting
//  xfer_done     in   1   1-cycle pulse: byte finished, xfer_rx valid
//  xfer_rx       in   8   byte received during the finished transfer
//  x_raw,y_raw,z_raw out 16 each  {H,L} sample registers
//  sample_valid  out  1   1-cycle pulse when x/y/z_raw update
//  init_done     out  1   level: configuration complete, sampling active
//  id_err        out  1   sticky: DEVID mismatch after ID_RETRIES attempts
//  overrun       out  1   sticky: a period tick arrived while a read frame was in flight
// BEHAVIOUR
//  Reset values: all outputs 0; state=PWRUP; counters 0; pend=0; retry count 0.
//  Byte rule: in each byte state, pulse xfer_start when xfer_busy=0 and pend=0, then set pend.
//   On xfer_done with pend=1: clear pend, capture xfer_rx, advance. xfer_done with pend=0 is ignored.
//  Frames (xfer_last=1 only on the final byte of each frame):
//   ID  : 0x0B,0x00,0x00 -> rx of byte 3 compared with 0xAD
//   FLT : 0x0A,0x2C,FILTER_CFG
//   PWR : 0x0A,0x2D,0x02
//   RD  : 0x0B,0x0E, then 6 dummy 0x00 -> XL,XH,YL,YH,ZL,ZH
//  States: PWRUP -> ID -> FLT -> PWR -> RUN(wait tick) -> RD -> PUBLISH -> RUN.
//   Also: ID mismatch -> PWRUP with retry+1; on the ID_RETRIES-th mismatch -> FAULT.
//  PWRUP: count PWRUP_TICKS cycles, then enter ID.
//  FAULT: absorbing until rst; id_err=1; xfer_start stays 0.
//  init_done goes high in the cycle after xfer_done of the PWR frame's last byte.
//   The period counter starts from 0 in that same cycle.
//  Period counter: free-running in RUN/RD/PUBLISH; wraps at PERIOD_TICKS-1; wrap = tick.
//   First tick occurs PERIOD_TICKS cycles after init_done rises.
//  Tick while idle in RUN: enter RD next cycle.
//  Tick while in RD/PUBLISH: tick dropped, overrun<=1 (sticky); the current frame completes.
//  PUBLISH: one cycle after ZH's xfer_done, x/y/z_raw load together and sample_valid=1 for
//   1 cycle. Partial frames never update the outputs.
//  Data is raw 16-bit {H,L}; no sign extension or scaling.
//  rst mid-frame: immediate return to reset values. No CS cleanup is issued
//   (the byte engine shares rst). A stale xfer_done is ignored via pend=0.
// TESTING
//  1 Reset, then model returns 0xAD -> xfer_tx sequence is 0B 00 00 | 0A 2C 13 | 0A 2D 02, with
//    xfer_last on bytes 3, 6 and 9. init_done rises 1 cycle after the 9th done.
//  2 Burst rx 34 12 78 56 BC 9A -> x=0x1234, y=0x5678, z=0x9ABC; sample_valid is 1 cycle wide.
//    Successive sample_valid pulses are exactly PERIOD_TICKS apart.
//  3 DEVID returns 0xE5 three times -> 3 ID frames, each PWRUP_TICKS apart; then id_err=1,
//    no further xfer_start.
//  4 Byte engine stretches done so a frame spans more than PERIOD_TICKS -> overrun=1, no
//    second frame overlaps, and the next sample still publishes correctly.
//  5 rst asserted after the 4th byte of a read frame -> next cycle all outputs 0 and state PWRUP.
//    x_raw is unchanged at 0 and init sequence replays.
//  6 Spurious xfer_done while pend=0, and xfer_busy=1 held 5 cycles -> no state advance.
//    xfer_start is withheld until busy drops.

Source files
------------

// File: rtl/acl_spi_scheduler.sv
// ADXL362 transaction sequencer: power-up wait, DEVID check, filter/power config,
// then periodic 6-byte X/Y/Z burst reads through a start/done byte engine.
module acl_spi_scheduler #(
  parameter int unsigned PWRUP_TICKS  = 24000,
  parameter int unsigned PERIOD_TICKS = 40000,
  parameter logic [7:0]  FILTER_CFG   = 8'h13,
  parameter int unsigned ID_RETRIES   = 3
) (
  input  logic        iclk,
  input  logic        rst,
  output logic        xfer_start,
  output logic [7:0]  xfer_tx,
  output logic        xfer_last,
  input  logic        xfer_busy,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_rx,
  output logic [15:0] x_raw,
  output logic [15:0] y_raw,
  output logic [15:0] z_raw,
  output logic        sample_valid,
  output logic        init_done,
  output logic        id_err,
  output logic        overrun
);

  localparam int unsigned MaxTicks = (PWRUP_TICKS > PERIOD_TICKS) ? PWRUP_TICKS : PERIOD_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);
  localparam int unsigned RetryW   = $clog2(ID_RETRIES + 1);

  typedef enum logic [2:0] {
    StPwrup, StId, StFlt, StPwr, StRun, StRd, StPublish, StFault
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic                pend_q, pend_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [4:0][7:0]     rd_q, rd_d;
  logic                xfer_start_q, xfer_start_d;
  logic [7:0]          xfer_tx_q, xfer_tx_d;
  logic                xfer_last_q, xfer_last_d;
  logic [15:0]         x_raw_q, x_raw_d, y_raw_q, y_raw_d, z_raw_q, z_raw_d;
  logic                sample_valid_q, sample_valid_d;
  logic                init_done_q, init_done_d;
  logic                id_err_q, id_err_d;
  logic                overrun_q, overrun_d;

  logic       byte_st, running, tick, frame_last;
  logic [7:0] frame_tx;

  always_comb begin
    frame_tx   = 8'h00;
    frame_last = 1'b0;
    unique case (state_q)
      StId: begin
        frame_tx   = (idx_q == 3'd0) ? 8'h0B : 8'h00;
        frame_last = (idx_q == 3'd2);
      end
      StFlt: begin
        frame_tx   = (idx_q == 3'd0) ? 8'h0A : (idx_q == 3'd1) ? 8'h2C : FILTER_CFG;
        frame_last = (idx_q == 3'd2);
      end
      StPwr: begin
        frame_tx   = (idx_q == 3'd0) ? 8'h0A : (idx_q == 3'd1) ? 8'h2D : 8'h02;
        frame_last = (idx_q == 3'd2);
      end
      StRd: begin
        frame_tx   = (idx_q == 3'd0) ? 8'h0B : (idx_q == 3'd1) ? 8'h0E : 8'h00;
        frame_last = (idx_q == 3'd7);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    pend_d         = pend_q;
    retry_d        = retry_q;
    rd_d           = rd_q;
    xfer_start_d   = 1'b0;
    xfer_tx_d      = 8'h00;
    xfer_last_d    = 1'b0;
    x_raw_d        = x_raw_q;
    y_raw_d        = y_raw_q;
    z_raw_d        = z_raw_q;
    sample_valid_d = 1'b0;
    init_done_d    = init_done_q;
    id_err_d       = id_err_q;
    overrun_d      = overrun_q;

    byte_st = (state_q == StId) || (state_q == StFlt) || (state_q == StPwr) || (state_q == StRd);
    running = (state_q == StRun) || (state_q == StRd) || (state_q == StPublish);
    tick    = running && (cnt_q == CntW'(PERIOD_TICKS - 1));

    if (running) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
      // A tick during an in-flight read is dropped; that frame still completes.
      if (tick && (state_q != StRun)) overrun_d = 1'b1;
    end

    if (byte_st && !pend_q && !xfer_busy) begin
      xfer_start_d = 1'b1;
      xfer_tx_d    = frame_tx;
      xfer_last_d  = frame_last;
      pend_d       = 1'b1;
    end

    case (state_q)
      StPwrup: begin
        if (cnt_q == CntW'(PWRUP_TICKS - 1)) begin
          state_d = StId;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (tick) begin
          state_d = StRd;
          idx_d   = 3'd0;
        end
      end
      StPublish: state_d = StRun;
      default: ;
    endcase

    if (byte_st && pend_q && xfer_done) begin
      pend_d = 1'b0;
      idx_d  = idx_q + 3'd1;
      if (frame_last) idx_d = 3'd0;
      unique case (state_q)
        StId: begin
          if (frame_last) begin
            if (xfer_rx == 8'hAD) begin
              state_d = StFlt;
            end else if (retry_q == RetryW'(ID_RETRIES - 1)) begin
              state_d  = StFault;
              id_err_d = 1'b1;
            end else begin
              retry_d = retry_q + RetryW'(1);
              state_d = StPwrup;
              cnt_d   = '0;
            end
          end
        end
        StFlt: if (frame_last) state_d = StPwr;
        StPwr: begin
          if (frame_last) begin
            state_d     = StRun;
            init_done_d = 1'b1;
            cnt_d       = '0;
          end
        end
        StRd: begin
          if (frame_last) begin
            x_raw_d        = {rd_q[1], rd_q[0]};
            y_raw_d        = {rd_q[3], rd_q[2]};
            z_raw_d        = {xfer_rx, rd_q[4]};
            sample_valid_d = 1'b1;
            state_d        = StPublish;
          end else if (idx_q >= 3'd2) begin
            rd_d[idx_q - 3'd2] = xfer_rx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q        <= StPwrup;
      cnt_q          <= '0;
      idx_q          <= 3'd0;
      pend_q         <= 1'b0;
      retry_q        <= '0;
      rd_q           <= '0;
      xfer_start_q   <= 1'b0;
      xfer_tx_q      <= 8'h00;
      xfer_last_q    <= 1'b0;
      x_raw_q        <= 16'h0000;
      y_raw_q        <= 16'h0000;
      z_raw_q        <= 16'h0000;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      id_err_q       <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      pend_q         <= pend_d;
      retry_q        <= retry_d;
      rd_q           <= rd_d;
      xfer_start_q   <= xfer_start_d;
      xfer_tx_q      <= xfer_tx_d;
      xfer_last_q    <= xfer_last_d;
      x_raw_q        <= x_raw_d;
      y_raw_q        <= y_raw_d;
      z_raw_q        <= z_raw_d;
      sample_valid_q <= sample_valid_d;
      init_done_q    <= init_done_d;
      id_err_q       <= id_err_d;
      overrun_q      <= overrun_d;
    end
  end

  assign xfer_start   = xfer_start_q;
  assign xfer_tx      = xfer_tx_q;
  assign xfer_last    = xfer_last_q;
  assign x_raw        = x_raw_q;
  assign y_raw        = y_raw_q;
  assign z_raw        = z_raw_q;
  assign sample_valid = sample_valid_q;
  assign init_done    = init_done_q;
  assign id_err       = id_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_acl_spi_scheduler.sv
// Bench for acl_spi_scheduler: behavioural byte engine plus tx/sample scoreboards.
module tb_acl_spi_scheduler;

  localparam int unsigned Pwrup  = 20;
  localparam int unsigned Period = 200;

  logic        iclk = 1'b0;
  logic        rst;
  logic        xfer_start, xfer_last, xfer_busy, xfer_done;
  logic [7:0]  xfer_tx, xfer_rx;
  logic [15:0] x_raw, y_raw, z_raw;
  logic        sample_valid, init_done, id_err, overrun;

  logic        eng_busy, eng_done, force_busy, spur_done;
  logic [7:0]  eng_rx;
  int          eng_lat;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cnt = 0;
  int sv_cnt = 0;
  int sv_cyc = 0;
  int sv_prev = 0;

  logic [8:0]  exp_tx[$];
  logic [7:0]  rx_q[$];
  logic [47:0] exp_smp[$];
  int          start_cyc[$];

  assign xfer_busy = eng_busy | force_busy;
  assign xfer_done = eng_done | spur_done;
  assign xfer_rx   = eng_rx;

  acl_spi_scheduler #(
    .PWRUP_TICKS (Pwrup),
    .PERIOD_TICKS(Period),
    .FILTER_CFG  (8'h13),
    .ID_RETRIES  (3)
  ) dut (
    .iclk        (iclk),
    .rst         (rst),
    .xfer_start  (xfer_start),
    .xfer_tx     (xfer_tx),
    .xfer_last   (xfer_last),
    .xfer_busy   (xfer_busy),
    .xfer_done   (xfer_done),
    .xfer_rx     (xfer_rx),
    .x_raw       (x_raw),
    .y_raw       (y_raw),
    .z_raw       (z_raw),
    .sample_valid(sample_valid),
    .init_done   (init_done),
    .id_err      (id_err),
    .overrun     (overrun)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_id(input logic [7:0] id);
    exp_tx.push_back(9'h00B); exp_tx.push_back(9'h000); exp_tx.push_back(9'h100);
    rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(id);
  endtask

  task automatic push_cfg();
    exp_tx.push_back(9'h00A); exp_tx.push_back(9'h02C); exp_tx.push_back(9'h113);
    exp_tx.push_back(9'h00A); exp_tx.push_back(9'h02D); exp_tx.push_back(9'h102);
    for (int i = 0; i < 6; i++) rx_q.push_back(8'h00);
  endtask

  task automatic push_rd(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    exp_tx.push_back(9'h00B); exp_tx.push_back(9'h00E);
    for (int i = 0; i < 5; i++) exp_tx.push_back(9'h000);
    exp_tx.push_back(9'h100);
    rx_q.push_back(8'h00); rx_q.push_back(8'h00);
    rx_q.push_back(x[7:0]); rx_q.push_back(x[15:8]);
    rx_q.push_back(y[7:0]); rx_q.push_back(y[15:8]);
    rx_q.push_back(z[7:0]); rx_q.push_back(z[15:8]);
    exp_smp.push_back({x, y, z});
  endtask

  // Byte engine: one done pulse eng_lat cycles after each accepted start.
  initial begin
    eng_busy = 1'b0;
    eng_done = 1'b0;
    eng_rx   = 8'h00;
    forever begin
      @(negedge iclk);
      if (xfer_start && !rst) begin
        eng_busy = 1'b1;
        repeat (eng_lat) @(negedge iclk);
        eng_busy = 1'b0;
        eng_done = 1'b1;
        eng_rx   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        done_cnt++;
        done_cyc = cyc;
        @(negedge iclk);
        eng_done = 1'b0;
      end
    end
  end

  always @(negedge iclk) begin
    if (!rst && xfer_start) begin
      start_cnt++;
      start_cyc.push_back(cyc);
      if (exp_tx.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL start_unexpected: observed 0x%0h required no start", {xfer_last, xfer_tx});
      end else begin
        check("tx_byte", {55'd0, xfer_last, xfer_tx}, {55'd0, exp_tx.pop_front()});
      end
    end
    if (!rst && sample_valid) begin
      sv_prev = sv_cyc;
      sv_cyc  = cyc;
      sv_cnt++;
      if (exp_smp.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sample_unexpected: observed 0x%0h required none", {x_raw, y_raw, z_raw});
      end else begin
        check("sample_xyz", {16'd0, x_raw, y_raw, z_raw}, {16'd0, exp_smp.pop_front()});
      end
    end
  end

  initial begin
    int base;
    int s0;
    int gap1;
    int gap2;
    rst        = 1'b1;
    force_busy = 1'b0;
    spur_done  = 1'b0;
    eng_lat    = 2;
    repeat (3) @(negedge iclk);
    check("reset_outputs",
          {2'd0, xfer_start, xfer_tx, xfer_last, x_raw, y_raw, z_raw, sample_valid, init_done,
           id_err, overrun}, 64'd0);

    // Init sequence with a good DEVID
    push_id(8'hAD);
    push_cfg();
    rst = 1'b0;
    for (int i = 0; i < 2000 && !init_done; i++) @(negedge iclk);
    check("init_done_rise", 64'(init_done), 64'd1);
    check("init_done_latency", 64'(cyc - done_cyc), 64'd1);
    check("init_byte_count", 64'(done_cnt), 64'd9);
    check("init_tx_drained", 64'(exp_tx.size()), 64'd0);

    // Two periodic burst reads
    push_rd(16'h1234, 16'h5678, 16'h9ABC);
    push_rd(16'h0F0E, 16'hA5C3, 16'h8001);
    for (int i = 0; i < 1000 && sv_cnt < 1; i++) @(negedge iclk);
    check("sample1_seen", 64'(sv_cnt), 64'd1);
    @(negedge iclk);
    check("sample_valid_width", 64'(sample_valid), 64'd0);
    for (int i = 0; i < 1000 && sv_cnt < 2; i++) @(negedge iclk);
    check("sample2_seen", 64'(sv_cnt), 64'd2);
    check("sample_spacing", 64'(sv_cyc - sv_prev), 64'(Period));
    check("overrun_clear", 64'(overrun), 64'd0);

    // Stretched engine: frame outlasts one period
    eng_lat = 30;
    push_rd(16'h2211, 16'h4433, 16'h6655);
    for (int i = 0; i < 1500 && sv_cnt < 3; i++) @(negedge iclk);
    check("sample3_seen", 64'(sv_cnt), 64'd3);
    check("overrun_set", 64'(overrun), 64'd1);
    @(negedge iclk);
    eng_lat = 2;
    push_rd(16'hBEEF, 16'hCAFE, 16'h7E57);
    for (int i = 0; i < 1500 && sv_cnt < 4; i++) @(negedge iclk);
    check("sample4_seen", 64'(sv_cnt), 64'd4);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Reset after the 4th byte of a read frame
    base = done_cnt;
    push_rd(16'h1111, 16'h2222, 16'h3333);
    for (int i = 0; i < 1000 && done_cnt < base + 4; i++) @(negedge iclk);
    check("mid_frame_bytes", 64'(done_cnt - base), 64'd4);
    rst = 1'b1;
    @(negedge iclk);
    check("mid_frame_reset_outputs",
          {2'd0, xfer_start, xfer_tx, xfer_last, x_raw, y_raw, z_raw, sample_valid, init_done,
           id_err, overrun}, 64'd0);
    exp_tx.delete();
    rx_q.delete();
    exp_smp.delete();

    // Busy held and spurious dones across power-up into the ID frame
    force_busy = 1'b1;
    repeat (2) @(negedge iclk);
    rst = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 30; i++) begin
      spur_done = (i == 22) || (i == 24) || (i == 27);
      @(negedge iclk);
    end
    spur_done = 1'b0;
    check("busy_withholds_start", 64'(start_cnt - s0), 64'd0);
    push_id(8'hAD);
    push_cfg();
    base = done_cnt;
    force_busy = 1'b0;
    for (int i = 0; i < 2000 && !init_done; i++) @(negedge iclk);
    check("replay_init_done", 64'(init_done), 64'd1);
    check("replay_byte_count", 64'(done_cnt - base), 64'd9);
    check("replay_x_raw_zero", 64'(x_raw), 64'd0);
    check("replay_no_sample", 64'(sv_cnt), 64'd4);

    // DEVID mismatch three times -> fault
    rst = 1'b1;
    repeat (2) @(negedge iclk);
    exp_tx.delete();
    rx_q.delete();
    start_cyc.delete();
    s0 = start_cnt;
    push_id(8'hE5);
    push_id(8'hE5);
    push_id(8'hE5);
    rst = 1'b0;
    for (int i = 0; i < 1000 && !id_err; i++) @(negedge iclk);
    check("id_err_set", 64'(id_err), 64'd1);
    check("id_frame_bytes", 64'(start_cnt - s0), 64'd9);
    if (start_cyc.size() == 9) begin
      gap1 = start_cyc[3] - start_cyc[0];
      gap2 = start_cyc[6] - start_cyc[3];
      check("id_retry_gap_equal", 64'(gap2), 64'(gap1));
      check("id_retry_gap_min", 64'(gap1 > int'(Pwrup)), 64'd1);
    end
    repeat (300) @(negedge iclk);
    check("fault_no_start", 64'(start_cnt - s0), 64'd9);
    check("fault_id_err_sticky", 64'(id_err), 64'd1);
    check("fault_no_init", 64'(init_done), 64'd0);
    check("fault_tx_drained", 64'(exp_tx.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
